// File: rtl/video_dsdac_out.sv
// Analogue-video output stage: a binomial FIR smooths the strobed composite samples,
// then a 1-bit delta-sigma modulator (order 1 or 2) runs on every clock of the same domain.
module video_dsdac_out #(
  parameter int C_DAT_W     = 10,
  parameter int C_FIR_ORDER = 2,
  parameter int C_DS_ORDER  = 1
) (
  input  logic               CK_i,
  input  logic               XAR_i,
  input  logic               CK_EE_i,
  input  logic [C_DAT_W-1:0] DATs_i,
  input  logic               MUTE_i,
  output logic [C_DAT_W-1:0] FIR_DATs_o,
  output logic               QQ_o
);

  localparam int C_SUM_W = C_DAT_W + C_FIR_ORDER;
  localparam logic [C_DAT_W-1:0] C_MID = {1'b1, {(C_DAT_W-1){1'b0}}};

  if (C_DAT_W < 6 || C_DAT_W > 16) begin : g_bad_dat_w
    $error("video_dsdac_out: C_DAT_W must be 6..16");
  end
  if (C_FIR_ORDER < 0 || C_FIR_ORDER > 3) begin : g_bad_fir_order
    $error("video_dsdac_out: C_FIR_ORDER must be 0..3");
  end
  if (C_DS_ORDER != 1 && C_DS_ORDER != 2) begin : g_bad_ds_order
    $error("video_dsdac_out: C_DS_ORDER must be 1 or 2");
  end

  function automatic int binom(input int n, input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // w_tap[0] is the incoming sample, w_tap[k] is delay register D[k-1].
  logic [C_DAT_W-1:0] w_tap [0:C_FIR_ORDER];
  assign w_tap[0] = DATs_i;

  for (genvar gi = 1; gi <= C_FIR_ORDER; gi++) begin : g_tap
    logic [C_DAT_W-1:0] r_d;
    always_ff @(posedge CK_i or negedge XAR_i) begin
      if (!XAR_i)       r_d <= '0;
      else if (CK_EE_i) r_d <= w_tap[gi-1];
    end
    assign w_tap[gi] = r_d;
  end

  logic [C_SUM_W-1:0] w_sum;
  always_comb begin
    w_sum = '0;
    for (int k = 0; k <= C_FIR_ORDER; k++)
      w_sum = w_sum + C_SUM_W'(binom(C_FIR_ORDER, k)) * C_SUM_W'(w_tap[k]);
  end

  logic [C_DAT_W-1:0] r_fir;
  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i)       r_fir <= '0;
    else if (CK_EE_i) r_fir <= C_DAT_W'(w_sum >> C_FIR_ORDER);
  end
  assign FIR_DATs_o = r_fir;

  logic [C_DAT_W-1:0] w_x;
  assign w_x = MUTE_i ? C_MID : r_fir;

  if (C_DS_ORDER == 1) begin : g_ds1
    logic [C_DAT_W-1:0] r_acc;
    logic               r_qq;
    logic [C_DAT_W:0]   w_acc_next;

    // The carry out of the modulo-2^W accumulate is the output bit.
    assign w_acc_next = {1'b0, r_acc} + {1'b0, w_x};

    always_ff @(posedge CK_i or negedge XAR_i) begin
      if (!XAR_i) begin
        r_acc <= '0;
        r_qq  <= 1'b0;
      end else begin
        r_acc <= w_acc_next[C_DAT_W-1:0];
        r_qq  <= w_acc_next[C_DAT_W];
      end
    end
    assign QQ_o = r_qq;
  end else begin : g_ds2
    localparam int C_I_W  = C_DAT_W + 4;
    localparam int C_E_W  = C_DAT_W + 6;
    localparam int C_IMAX = (1 << (C_I_W - 1)) - 1;
    localparam int C_IMIN = -(1 << (C_I_W - 1));
    localparam int C_XLO  = 1 << (C_DAT_W - 4);
    localparam int C_XHI  = (1 << C_DAT_W) - C_XLO;
    localparam logic signed [C_E_W-1:0] C_EMAX = C_E_W'(C_IMAX);
    localparam logic signed [C_E_W-1:0] C_EMIN = C_E_W'(C_IMIN);
    localparam logic signed [C_E_W-1:0] C_EFB  = C_E_W'(1 << C_DAT_W);

    function automatic logic signed [C_I_W-1:0] sat(input logic signed [C_E_W-1:0] v);
      if (v > C_EMAX)      return C_I_W'(C_IMAX);
      else if (v < C_EMIN) return C_I_W'(C_IMIN);
      else                 return v[C_I_W-1:0];
    endfunction

    logic signed [C_I_W-1:0] r_i1, r_i2;
    logic                    r_qq;
    logic [C_DAT_W-1:0]      w_xc;
    logic signed [C_E_W-1:0] w_fb, w_i1_sum, w_i2_sum;
    logic signed [C_I_W-1:0] w_i1_new, w_i2_new;

    // Keeping X away from the rails keeps the second-order loop stable.
    assign w_xc = (w_x < C_DAT_W'(C_XLO)) ? C_DAT_W'(C_XLO) :
                  (w_x > C_DAT_W'(C_XHI)) ? C_DAT_W'(C_XHI) : w_x;
    assign w_fb     = r_qq ? C_EFB : '0;
    assign w_i1_sum = $signed(C_E_W'(r_i1)) + $signed(C_E_W'(w_xc)) - w_fb;
    assign w_i1_new = sat(w_i1_sum);
    assign w_i2_sum = $signed(C_E_W'(r_i2)) + $signed(C_E_W'(w_i1_new)) - w_fb;
    assign w_i2_new = sat(w_i2_sum);

    always_ff @(posedge CK_i or negedge XAR_i) begin
      if (!XAR_i) begin
        r_i1 <= '0;
        r_i2 <= '0;
        r_qq <= 1'b0;
      end else begin
        r_i1 <= w_i1_new;
        r_i2 <= w_i2_new;
        r_qq <= ~w_i2_new[C_I_W-1];
      end
    end
    assign QQ_o = r_qq;
  end

endmodule

// File: tb/tb_video_dsdac_out.sv
// Bench for video_dsdac_out: four instances (FIR order 2/0/3 with first-order DAC,
// FIR order 2 with second-order DAC) share one stimulus stream.
module tb_video_dsdac_out;
  localparam int W = 10;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         ee    = 1'b0;
  logic         mute  = 1'b0;
  logic [W-1:0] dat   = '0;
  logic [W-1:0] fir_a, fir_b, fir_c, fir_d;
  logic         qq_a, qq_b, qq_c, qq_d;

  always #5 clk = ~clk;

  video_dsdac_out #(.C_DAT_W(W), .C_FIR_ORDER(2), .C_DS_ORDER(1)) u_a (
    .CK_i(clk), .XAR_i(rst_n), .CK_EE_i(ee), .DATs_i(dat), .MUTE_i(mute),
    .FIR_DATs_o(fir_a), .QQ_o(qq_a));
  video_dsdac_out #(.C_DAT_W(W), .C_FIR_ORDER(0), .C_DS_ORDER(1)) u_b (
    .CK_i(clk), .XAR_i(rst_n), .CK_EE_i(ee), .DATs_i(dat), .MUTE_i(mute),
    .FIR_DATs_o(fir_b), .QQ_o(qq_b));
  video_dsdac_out #(.C_DAT_W(W), .C_FIR_ORDER(3), .C_DS_ORDER(1)) u_c (
    .CK_i(clk), .XAR_i(rst_n), .CK_EE_i(ee), .DATs_i(dat), .MUTE_i(mute),
    .FIR_DATs_o(fir_c), .QQ_o(qq_c));
  video_dsdac_out #(.C_DAT_W(W), .C_FIR_ORDER(2), .C_DS_ORDER(2)) u_d (
    .CK_i(clk), .XAR_i(rst_n), .CK_EE_i(ee), .DATs_i(dat), .MUTE_i(mute),
    .FIR_DATs_o(fir_d), .QQ_o(qq_d));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end else
      $display("ok   %s value=%0d window=%0d..%0d", name, act, lo, hi);
  endtask

  // ---------------- reference model ----------------
  function automatic int fact(input int n);
    int r = 1;
    for (int i = 2; i <= n; i++) r = r * i;
    return r;
  endfunction

  function automatic int binom(input int n, input int k);
    return fact(n) / (fact(k) * fact(n - k));
  endfunction

  function automatic logic [W-1:0] fir_ref(input int n, input int x0, input int x1,
                                           input int x2, input int x3);
    int tap [4];
    int acc = 0;
    tap[0] = x0; tap[1] = x1; tap[2] = x2; tap[3] = x3;
    for (int k = 0; k <= n; k++) acc += binom(n, k) * tap[k];
    return W'(acc >> n);
  endfunction

  function automatic int ord(input int j);
    case (j)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  // Index 0/1/2 model instances u_a/u_b/u_c; u_d shares u_a's FIR.
  longint       m_s   [3] = '{0, 0, 0};
  logic [W-1:0] m_fir [3] = '{'0, '0, '0};
  logic         m_qq  [3] = '{1'b0, 1'b0, 1'b0};
  logic [W-1:0] m_h   [3] = '{'0, '0, '0};

  function automatic longint xval(input int j);
    return mute ? longint'(1 << (W - 1)) : longint'(m_fir[j]);
  endfunction

  // First-order DAC: after t clocks from zero, ones so far = floor(sum(X)/2^W).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 3; j++) begin
        m_s[j]   <= 0;
        m_fir[j] <= '0;
        m_qq[j]  <= 1'b0;
        m_h[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < 3; j++) begin
        m_s[j]  <= m_s[j] + xval(j);
        m_qq[j] <= (((m_s[j] + xval(j)) >> W) != (m_s[j] >> W));
        if (ee) m_fir[j] <= fir_ref(ord(j), dat, m_h[0], m_h[1], m_h[2]);
      end
      if (ee) begin
        m_h[0] <= dat;
        m_h[1] <= m_h[0];
        m_h[2] <= m_h[1];
      end
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("cyc_fir_a", fir_a, m_fir[0]);
      check("cyc_fir_b", fir_b, m_fir[1]);
      check("cyc_fir_c", fir_c, m_fir[2]);
      check("cyc_fir_d", fir_d, m_fir[0]);
      check("cyc_qq_a", qq_a, m_qq[0]);
      check("cyc_qq_b", qq_b, m_qq[1]);
      check("cyc_qq_c", qq_c, m_qq[2]);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // ---------------- directed helpers ----------------
  task automatic mid_reset(input string tag);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check({tag, "_fir_a"}, fir_a, 0);
    check({tag, "_fir_b"}, fir_b, 0);
    check({tag, "_fir_c"}, fir_c, 0);
    check({tag, "_fir_d"}, fir_d, 0);
    check({tag, "_qq_a"}, qq_a, 0);
    check({tag, "_qq_b"}, qq_b, 0);
    check({tag, "_qq_c"}, qq_c, 0);
    check({tag, "_qq_d"}, qq_d, 0);
    $display("reset %s applied between edges", tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic strobe(input logic [W-1:0] v);
    @(negedge clk);
    ee  = 1'b1;
    dat = v;
    @(negedge clk);
    ee  = 1'b0;
  endtask

  task automatic count_ones(input int which, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cnt += (which == 1) ? int'(qq_b) : int'(qq_d);
    end
  endtask

  typedef struct {
    logic [W-1:0] d;
    int           exp2;
    int           exp3;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int cnt, bad, last, gap;

    tbl[0] = '{10'd0,    0,   0};
    tbl[1] = '{10'd400,  100, 50};
    tbl[2] = '{10'd400,  300, 200};
    tbl[3] = '{10'd400,  400, 350};
    tbl[4] = '{10'd400,  400, 400};
    tbl[5] = '{10'd1023, 255, 127};
    tbl[6] = '{10'd0,    511, 383};
    tbl[7] = '{10'd0,    255, 383};
    tbl[8] = '{10'd0,    0,   127};
    tbl[9] = '{10'd0,    0,   0};

    repeat (2) @(negedge clk);
    check("reset_fir_a", fir_a, 0);
    check("reset_fir_c", fir_c, 0);
    check("reset_qq_b", qq_b, 0);
    check("reset_qq_d", qq_d, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Strobe every 3rd clock; check one clock after the strobe and while held.
    for (int i = 0; i < 10; i++) begin
      if (i == 5) mid_reset("rst_mid1");
      strobe(tbl[i].d);
      check($sformatf("tbl%0d_fir2", i), fir_a, tbl[i].exp2);
      check($sformatf("tbl%0d_fir3", i), fir_c, tbl[i].exp3);
      check($sformatf("tbl%0d_fir0", i), fir_b, tbl[i].d);
      @(negedge clk);
      check($sformatf("tbl%0d_hold2", i), fir_a, tbl[i].exp2);
      check($sformatf("tbl%0d_hold3", i), fir_c, tbl[i].exp3);
      $display("vec %0d d=%0d fir2=%0d fir3=%0d", i, tbl[i].d, fir_a, fir_c);
    end

    // History is discarded by reset: first strobe behaves as after zeros.
    strobe(10'd700);
    mid_reset("rst_mid2");
    strobe(10'd400);
    check("post_rst_fir2", fir_a, 100);
    check("post_rst_fir3", fir_c, 50);
    $display("post-reset strobe 400 -> fir2=%0d fir3=%0d", fir_a, fir_c);

    // First-order DAC with X=256: 256 ones in 1024 clocks, one every 4th.
    strobe(10'd256);
    @(negedge clk);
    cnt = 0; bad = 0; last = -1;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      if (qq_b) begin
        cnt++;
        gap = i - last;
        if (last >= 0 && gap != 4) bad++;
        last = i;
      end
    end
    check("ds1_x256_ones", cnt, 256);
    check("ds1_x256_period", bad, 0);
    $display("ds1 x=256 ones=%0d period_errors=%0d", cnt, bad);

    // Mute forces mid-scale, then release returns X to the FIR output (0).
    @(negedge clk);
    mute = 1'b1;
    strobe(10'd0);
    @(negedge clk);
    count_ones(1, 1024, cnt);
    check("mute_ones", cnt, 512);
    $display("mute ones=%0d", cnt);
    @(negedge clk);
    mute = 1'b0;
    count_ones(1, 1024, cnt);
    check("unmute_ones", cnt, 0);
    $display("unmute ones=%0d", cnt);

    // Randomised stream, first at full strobe rate then sparse.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ee  = (i < 300) ? 1'b1 : ($urandom_range(0, 2) == 0);
      dat = W'($urandom);
      if ($urandom_range(0, 31) == 0) mute = ~mute;
    end
    @(negedge clk);
    ee   = 1'b0;
    mute = 1'b0;
    $display("random phase done checks=%0d", checks);

    // Second-order DAC: bottom clamp, mid value, top clamp.
    mid_reset("rst_ds2");
    repeat (3) strobe(10'd0);
    repeat (100) @(negedge clk);
    count_ones(3, 4096, cnt);
    check_range("ds2_x0_clamp", cnt, 254, 258);
    repeat (3) strobe(10'd700);
    repeat (200) @(negedge clk);
    count_ones(3, 4096, cnt);
    check_range("ds2_x700", cnt, 2796, 2804);
    repeat (3) strobe(10'd1023);
    repeat (200) @(negedge clk);
    count_ones(3, 4096, cnt);
    check_range("ds2_x1023_clamp", cnt, 3836, 3844);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
